// File: rtl/y86_mem_stage.sv
// Purpose: Y-86 data-memory stage; one 8-byte little-endian access per request, with a byte preload port.
// Latency: start sampled at edge k commits at edge k+1+WAIT_STATES; done pulses for the following cycle.
// Backpressure: ready_o is high only in IDLE; a start seen outside IDLE is dropped, never queued.
//
// Ports:
//   clk_i, reset_i              clock; synchronous active-high reset (control state only, not memory)
//   start_i, icode_i            request strobe and instruction code
//   valA_i, valE_i, valP_i      operands; the address and write data are picked from these by icode
//   init_we_i/addr_i/data_i     byte preload, ignored while BUSY or when the address is out of range
//   ready_o, done_o             IDLE indicator; one-cycle completion pulse
//   valM_o, mem_err_o           registered read data and address fault, held until the next commit
//
// Optional feature: define MEM_STAGE_ALIGN_CHECK_EN to make misaligned (addr[2:0]!=0) accesses fault.
module y86_mem_stage #(
  parameter int DEPTH_BYTES = 1024,
  parameter int WAIT_STATES = 0,
  parameter int CNT_W       = 4
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic [3:0]  icode_i,
  input  logic [63:0] valA_i,
  input  logic [63:0] valE_i,
  input  logic [63:0] valP_i,
  input  logic        init_we_i,
  input  logic [63:0] init_addr_i,
  input  logic [7:0]  init_data_i,
  output logic        ready_o,
  output logic        done_o,
  output logic [63:0] valM_o,
  output logic        mem_err_o
);

  localparam int AW = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [3:0]        icode_q;
  logic [63:0]       addr_q;
  logic [63:0]       wdata_q;
  logic [63:0]       valM_q;
  logic              mem_err_q;

  logic [7:0]        mem_q [DEPTH_BYTES];

  // Request-side operand selection: pops and returns address through valA,
  // everything else through valE; call stores the return address valP.
  logic [63:0]       req_addr;
  logic [63:0]       req_wdata;

  // Access-side decode on the latched request.
  logic              is_rd;
  logic              is_wr;
  logic              commit;
  logic [64:0]       end_addr;
  logic              range_err;
  logic              align_err;
  logic              acc_err;
  logic [AW-1:0]     byte_idx [8];
  logic [63:0]       rd_data;

  always_comb begin
    req_addr  = ((icode_i == 4'hB) || (icode_i == 4'h9)) ? valA_i : valE_i;
    req_wdata = (icode_i == 4'h8) ? valP_i : valA_i;
  end

  always_comb begin
    is_rd  = (icode_q == 4'h5) || (icode_q == 4'hB) || (icode_q == 4'h9);
    is_wr  = (icode_q == 4'h4) || (icode_q == 4'hA) || (icode_q == 4'h8);
    commit = (state_q == S_BUSY) && (cnt_q == '0);
    // 65-bit sum so an address near 2^64 cannot wrap back into range.
    end_addr  = {1'b0, addr_q} + 65'd8;
    range_err = end_addr > 65'(DEPTH_BYTES);
`ifdef MEM_STAGE_ALIGN_CHECK_EN
    align_err = |addr_q[2:0];
`else
    align_err = 1'b0;
`endif
    acc_err = range_err | align_err;
  end

  // Byte lanes; the index only matters when the range check passes, so the
  // truncation to AW bits is exact whenever the result is used.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < 8; i++) begin
      byte_idx[i]       = addr_q[AW-1:0] + AW'(i);
      rd_data[8*i +: 8] = mem_q[byte_idx[i]];
    end
  end

  // FSM: state register plus control and result registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      icode_q   <= 4'h0;
      addr_q    <= '0;
      wdata_q   <= '0;
      valM_q    <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if ((state_q == S_IDLE) && start_i) begin
        icode_q <= icode_i;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        cnt_q   <= CNT_W'(WAIT_STATES);
      end else if ((state_q == S_BUSY) && (cnt_q != '0)) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      if (commit) begin
        valM_q    <= (is_rd && !acc_err) ? rd_data : 64'd0;
        mem_err_q <= (is_rd || is_wr) && acc_err;
      end
    end
  end

  // FSM: next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i) state_d = S_BUSY;
      S_BUSY:  if (cnt_q == '0) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs.
  always_comb begin
    ready_o   = (state_q == S_IDLE);
    done_o    = (state_q == S_DONE);
    valM_o    = valM_q;
    mem_err_o = mem_err_q;
  end

  // Memory array: no reset. A store commits all 8 bytes on one edge; reset on
  // that edge discards it. Preload never collides with a store because stores
  // only commit in BUSY, where preload is blocked.
  always_ff @(posedge clk_i) begin
    if (!reset_i && commit && is_wr && !acc_err) begin
      for (int i = 0; i < 8; i++) begin
        mem_q[byte_idx[i]] <= wdata_q[8*i +: 8];
      end
    end
    if (init_we_i && (state_q != S_BUSY) && (init_addr_i < 64'(DEPTH_BYTES))) begin
      mem_q[init_addr_i[AW-1:0]] <= init_data_i;
    end
  end

endmodule

// File: tb/tb_y86_mem_stage.sv
// Purpose: directed plus random checking of y86_mem_stage against a byte-array reference model.
// Latency: instance 0 runs with WAIT_STATES=0, instance 1 with WAIT_STATES=3.
// Backpressure: spurious starts while busy and preloads while busy are exercised on instance 1.
module tb_y86_mem_stage;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic [1:0]  rst;
  logic [1:0]  start;
  logic [3:0]  icode;
  logic [63:0] valA, valE, valP;
  logic        init_we;
  logic [63:0] init_addr;
  logic [7:0]  init_data;
  logic [1:0]  rdy, dn, merr;
  logic [63:0] valm [2];

  logic [7:0]  mdl_mem [2][DEPTH];
  int          n_chk  = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  y86_mem_stage #(.DEPTH_BYTES(DEPTH), .WAIT_STATES(0), .CNT_W(4)) u_dut0 (
    .clk_i(clk), .reset_i(rst[0]), .start_i(start[0]), .icode_i(icode),
    .valA_i(valA), .valE_i(valE), .valP_i(valP),
    .init_we_i(init_we), .init_addr_i(init_addr), .init_data_i(init_data),
    .ready_o(rdy[0]), .done_o(dn[0]), .valM_o(valm[0]), .mem_err_o(merr[0])
  );

  y86_mem_stage #(.DEPTH_BYTES(DEPTH), .WAIT_STATES(3), .CNT_W(4)) u_dut1 (
    .clk_i(clk), .reset_i(rst[1]), .start_i(start[1]), .icode_i(icode),
    .valA_i(valA), .valE_i(valE), .valP_i(valP),
    .init_we_i(init_we), .init_addr_i(init_addr), .init_data_i(init_data),
    .ready_o(rdy[1]), .done_o(dn[1]), .valM_o(valm[1]), .mem_err_o(merr[1])
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference behaviour: decode the icode, range/alignment check, then move bytes.
  task automatic model(input int d, input logic [3:0] ic, input logic [63:0] a,
                       input logic [63:0] e, input logic [63:0] p,
                       output logic [63:0] m, output logic er);
    logic [63:0] addr, wd;
    logic        rd, wr;
    int          base;
    addr = (ic == 4'hB || ic == 4'h9) ? a : e;
    wd   = (ic == 4'h8) ? p : a;
    rd   = (ic == 4'h5 || ic == 4'hB || ic == 4'h9);
    wr   = (ic == 4'h4 || ic == 4'hA || ic == 4'h8);
    m    = 64'd0;
    er   = 1'b0;
    if (rd || wr) begin
      er = ({1'b0, addr} + 65'd8) > 65'(DEPTH);
`ifdef MEM_STAGE_ALIGN_CHECK_EN
      if (addr % 8 != 0) er = 1'b1;
`endif
      if (!er) begin
        base = int'(addr[31:0]);
        for (int i = 0; i < 8; i++) begin
          if (wr) mdl_mem[d][base + i] = wd[8*i +: 8];
          else    m[8*i +: 8] = mdl_mem[d][base + i];
        end
      end
    end
  endtask

  task automatic preload(input logic [63:0] addr, input logic [7:0] data);
    @(negedge clk);
    init_we   = 1'b1;
    init_addr = addr;
    init_data = data;
    if (addr < 64'(DEPTH)) begin
      mdl_mem[0][int'(addr[31:0])] = data;
      mdl_mem[1][int'(addr[31:0])] = data;
    end
    @(negedge clk);
    init_we = 1'b0;
  endtask

  // One request on instance d with cycle-by-cycle checks of done/ready/results.
  // spur: second start sampled at edge k+2 (must be ignored).
  // rst_mid: reset sampled at edge k+1 while BUSY (no done, no write).
  // pre_busy: preload at edge k+2 while instance d is BUSY (dropped there only).
  task automatic req(input int d, input logic [3:0] ic, input logic [63:0] a,
                     input logic [63:0] e, input logic [63:0] p,
                     input bit spur, input bit rst_mid, input bit pre_busy);
    int          w;
    logic [63:0] exp_m;
    logic        exp_e;
    w = (d == 0) ? 0 : 3;
    exp_m = 64'd0;
    exp_e = 1'b0;
    if (!rst_mid) model(d, ic, a, e, p, exp_m, exp_e);
    @(negedge clk);
    icode = ic; valA = a; valE = e; valP = p;
    start[d] = 1'b1;
    for (int n = 0; n <= w + 2; n++) begin
      @(negedge clk);
      if (rst_mid) begin
        if (n >= 1) begin
          check("rst_ready", 64'(rdy[d]), 64'd1);
          check("rst_done", 64'(dn[d]), 64'd0);
          check("rst_valM", valm[d], 64'd0);
          check("rst_err", 64'(merr[d]), 64'd0);
        end
      end else begin
        check("done", 64'(dn[d]), 64'((n == w + 1) ? 1 : 0));
        check("ready", 64'(rdy[d]), 64'((n == w + 2) ? 1 : 0));
        if (n >= w + 1) begin
          check("valM", valm[d], exp_m);
          check("mem_err", 64'(merr[d]), 64'(exp_e));
        end
      end
      if (n == 0) begin
        start[d] = 1'b0;
        if (rst_mid) rst[d] = 1'b1;
      end
      if (n == 1) begin
        rst[d] = 1'b0;
        if (spur) begin
          start[d] = 1'b1; icode = 4'h4; valE = 64'd400; valA = 64'hDEADBEEFCAFEF00D;
        end
        if (pre_busy) begin
          init_we = 1'b1; init_addr = 64'd300; init_data = 8'h5A;
          mdl_mem[1-d][300] = 8'h5A;
        end
      end
      if (n == 2) begin
        start[d] = 1'b0;
        init_we  = 1'b0;
      end
    end
  endtask

  initial begin
    rst = 2'b11; start = 2'b00; icode = 4'h0;
    valA = '0; valE = '0; valP = '0;
    init_we = 1'b0; init_addr = '0; init_data = '0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("rst_ready0", 64'(rdy[d]), 64'd1);
      check("rst_done0", 64'(dn[d]), 64'd0);
      check("rst_valM0", valm[d], 64'd0);
      check("rst_err0", 64'(merr[d]), 64'd0);
    end
    rst = 2'b00;

    for (int i = 0; i < DEPTH; i++) preload(64'(i), 8'($urandom));
    for (int i = 0; i < 8; i++) preload(64'(64 + i), 8'(i + 1));
    preload(64'd1928, 8'hEE);  // out of range: must not alias onto byte 904

    req(0, 4'h5, 64'd0, 64'd64, 64'd0, 0, 0, 0);
    check("spec_ld64", valm[0], 64'h0807060504030201);

    req(0, 4'h4, 64'h1122334455667788, 64'd100, 64'd0, 0, 0, 0);
    req(0, 4'h5, 64'd0, 64'd100, 64'd0, 0, 0, 0);
    check("spec_ld100", valm[0], 64'h1122334455667788);

    req(0, 4'h8, 64'd0, 64'd1016, 64'h40, 0, 0, 0);
    req(0, 4'h9, 64'd1016, 64'd0, 64'd0, 0, 0, 0);
    check("spec_ret", valm[0], 64'h40);
    req(0, 4'hA, 64'h0123456789ABCDEF, 64'd1017, 64'd0, 0, 0, 0);
    check("spec_push_err", 64'(merr[0]), 64'd1);
    req(0, 4'h5, 64'd0, 64'd1016, 64'd0, 0, 0, 0);
    req(0, 4'h4, 64'h55, 64'hFFFFFFFFFFFFFFFC, 64'd0, 0, 0, 0);
    check("spec_wrap_err", 64'(merr[0]), 64'd1);
    req(0, 4'h0, 64'd8, 64'd8, 64'd8, 0, 0, 0);
    req(0, 4'h5, 64'd0, 64'd904, 64'd0, 0, 0, 0);

    req(1, 4'h5, 64'd0, 64'd64, 64'd0, 1, 0, 0);
    req(1, 4'h5, 64'd0, 64'd400, 64'd0, 0, 0, 0);
    req(1, 4'h4, 64'hA5A5A5A5A5A5A5A5, 64'd200, 64'd0, 0, 1, 0);
    req(1, 4'h5, 64'd0, 64'd200, 64'd0, 0, 0, 0);
    req(1, 4'h5, 64'd0, 64'd0, 64'd0, 0, 0, 1);
    req(1, 4'h5, 64'd0, 64'd296, 64'd0, 0, 0, 0);
    req(0, 4'h5, 64'd0, 64'd296, 64'd0, 0, 0, 0);

    req(0, 4'h5, 64'd0, 64'd65, 64'd0, 0, 0, 0);
`ifdef MEM_STAGE_ALIGN_CHECK_EN
    check("spec_unaligned", 64'(merr[0]), 64'd1);
`else
    check("spec_unaligned", 64'(merr[0]), 64'd0);
`endif

    for (int i = 0; i < 50; i++) begin
      logic [3:0]  ic;
      logic [63:0] addr, rnd, a, e, p;
      int          r;
      ic = 4'($urandom_range(0, 15));
      r  = int'($urandom_range(0, 9));
      if (r == 0)      addr = {$urandom(), $urandom()};
      else if (r == 1) addr = 64'($urandom_range(1010, 1023));
      else             addr = 64'($urandom_range(0, 1016));
      rnd = {$urandom(), $urandom()};
      p   = {$urandom(), $urandom()};
      a   = (ic == 4'hB || ic == 4'h9) ? addr : rnd;
      e   = (ic == 4'hB || ic == 4'h9) ? rnd : addr;
      req((i % 5 == 4) ? 1 : 0, ic, a, e, p, 0, 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/y86_mem_stage.md
# y86_mem_stage

- Parametrised, multi-cycle data-memory stage for the sequential Y-86 processor.
- Sits after execute and before write-back:
  - takes icode, valA, valE and valP;
  - performs the single 8-byte little-endian access the instruction requires, with configurable wait states and a start/done handshake;
  - returns valM and mem_err.
- Owns the byte-addressed data memory array and exposes a byte-wide preload port for benches and boot code.

## Interface
- DEPTH_BYTES, 1024: data memory size in bytes; legal addresses 0..DEPTH_BYTES-1.
- WAIT_STATES, 0: extra cycles spent in BUSY before the access commits (0..15).
- CNT_W, 4: width of the wait-state counter; must hold WAIT_STATES.
- clk  in  1: clock, all state updates on rising edge.
- reset  in  1: synchronous, active-high; clears control state only, not memory contents.
- start  in  1: request strobe, accepted only when ready=1.
- icode  in  4: instruction code of the request.
- valA  in  64: register A value (write data, or pop/ret address).
- valE  in  64: ALU result (store/load/push/call address).
- valP  in  64: next PC (call write data).
- init_we  in  1: preload byte write enable.
- init_addr  in  64: preload byte address.
- init_data  in  8: preload byte.
- ready  out  1: high in IDLE; request may be issued.
- done  out  1: one-cycle pulse; valM and mem_err valid.
- valM  out  64: read data; 0 for non-reads and on error.
- mem_err  out  1: address fault for this request; held with done.

## Operation
- FSM states: IDLE, BUSY, DONE.
  - IDLE→BUSY on start: latch icode, address, write data; load counter with WAIT_STATES.
  - BUSY with counter>0: decrement.
  - BUSY with counter==0: perform the access; go to DONE.
  - DONE→IDLE unconditionally.
- start outside IDLE is ignored, with no queuing.
- Address and data selection by icode:
  - 4 rmmovq: write valA to M[valE].
  - 5 mrmovq: read M[valE].
  - A pushq: write valA to M[valE].
  - B popq: read M[valA].
  - 8 call: write valP to M[valE].
  - 9 ret: read M[valA].
  - All other icodes: no access; valM=0 and mem_err=0, with the same latency.
- Little-endian: byte at addr holds bits [7:0], addr+7 holds bits [63:56].
- Range check:
  - computed in 65 bits;
  - mem_err=1 if addr+8 > DEPTH_BYTES (this covers 64-bit wrap);
  - on error: no byte is written, valM=0.
- Preload:
  - init_we writes init_data to M[init_addr] when the state is not BUSY and init_addr<DEPTH_BYTES;
  - otherwise the preload write is dropped.
- Simultaneous preload and DONE-cycle: the preload write lands; the request access has already committed.

## Timing
- Reset values: state=IDLE, ready=1, done=0, valM=0, mem_err=0, counter=0.
- Latency:
  - start sampled at edge k;
  - access commits at edge k+1+WAIT_STATES;
  - done is high for exactly one cycle after that edge;
  - ready returns at edge k+2+WAIT_STATES.
- Minimum request spacing: WAIT_STATES+2 cycles.
- valM and mem_err stay registered and hold their value after done until the next access commits or reset.
- Reset mid-operation (BUSY or DONE):
  - returns to IDLE at that edge;
  - any pending write is discarded;
  - done is not asserted.
- Write commit is atomic: all 8 bytes are written on the same edge.

## Configuration
- MEM_STAGE_ALIGN_CHECK_EN
  - Defined: an access whose address[2:0]!=0 also raises mem_err, with no write and valM=0.
  - Undefined: unaligned accesses are legal and byte-exact.

## Test plan
- Preload M[64..71]=01..08 via init port. Issue mrmovq (icode 5), valE=64, WAIT_STATES=0 -> done at edge k+1, valM=0x0807060504030201, mem_err=0.
- Issue rmmovq (icode 4), valA=0x1122334455667788, valE=100, then mrmovq at 100 -> valM=0x1122334455667788; M[100]=0x88.
- Issue call (icode 8), valP=0x40, valE=1016, then ret (icode 9), valA=1016 -> valM=0x40. Issue pushq, valE=1017 -> mem_err=1, valM=0, M[1017..1023] unchanged. Issue valE=0xFFFFFFFFFFFFFFFC -> mem_err=1.
- WAIT_STATES=3: start at edge k -> done only at edge k+4. A second start at k+2 is ignored. ready=1 again at k+5.
- Assert reset in BUSY during rmmovq to address 200 -> no done pulse, M[200..207] unchanged, ready=1 next cycle.
- With MEM_STAGE_ALIGN_CHECK_EN: mrmovq at 65 -> mem_err=1. Without it: valM equals bytes 65..72.
